ren_tile_dispatch: RTL

REN_TILE_DISPATCH -- requirements
Module: ren_tile_dispatch

---
 rtl/ren_tile_dispatch_pkg.sv | 35 +++
 rtl/ren_span_walker.sv | 112 +++++++++++
 rtl/ren_tile_dispatch.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/ren_tile_dispatch_pkg.sv
// Shared renderer types: tile descriptors from the shader queue, spans to the shaders,
// the dispatcher state encoding and a saturating counter helper.
package ren_tile_dispatch_pkg;

    localparam int REN_COORD_W = 11;
    localparam int REN_LANES   = 4;
    localparam int MAX_TILE    = 16;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_EMIT = 1'b1
    } disp_state_t;

    typedef struct packed {
        logic [REN_COORD_W-1:0] x;
        logic [REN_COORD_W-1:0] y;
        logic [4:0]             size;
    } tile_desc_t;

    typedef struct packed {
        logic [REN_COORD_W-1:0] x;
        logic [REN_COORD_W-1:0] y;
        logic [REN_LANES-1:0]   mask;
        logic                   last;
    } span_t;

    function automatic logic [15:0] sat_inc16(input logic [15:0] value);
        if (value == 16'hFFFF) begin
            return value;
        end else begin
            return value + 16'd1;
        end
    endfunction

endpackage

// File: rtl/ren_span_walker.sv
// Row-major span address generator: holds the span being presented and computes the
// next span (position, lane mask and last flag) on load or advance.
module ren_span_walker
    import ren_tile_dispatch_pkg::*;
#(
    parameter int COORD_W  = 11,
    parameter int SCREEN_W = 1280,
    parameter int SCREEN_H = 720,
    parameter int LANES    = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic               advance,
    input  logic [COORD_W-1:0] tile_x,
    input  logic [COORD_W-1:0] tile_y,
    input  logic [4:0]         tile_size,
    output logic [COORD_W-1:0] span_x,
    output logic [COORD_W-1:0] span_y,
    output logic [LANES-1:0]   span_mask,
    output logic               span_last
);

    // One extra bit keeps origin + offset from wrapping near the coordinate limit.
    localparam int CW1 = COORD_W + 1;
    localparam logic [CW1-1:0] SW_C    = CW1'(SCREEN_W);
    localparam logic [CW1-1:0] SH_C    = CW1'(SCREEN_H);
    localparam logic [CW1-1:0] LANES_C = CW1'(LANES);
    localparam logic [CW1-1:0] ONE_C   = CW1'(1);

    logic [CW1-1:0]     x0_r, y0_r, size_r, col_r, row_r;
    logic [COORD_W-1:0] span_x_r, span_y_r;
    logic [LANES-1:0]   mask_r;
    logic               last_r;

    logic [CW1-1:0]     base_x0_s, base_y0_s, base_size_s;
    logic [CW1-1:0]     nxt_col_s, nxt_row_s, nxt_x_s, nxt_y_s;
    logic [LANES-1:0]   nxt_mask_s;
    logic               nxt_last_s, step_col_s, more_cols_s, more_rows_s;

    // Select tile parameters and the position of the span to present next.
    always_comb begin
        base_x0_s   = x0_r;
        base_y0_s   = y0_r;
        base_size_s = size_r;
        nxt_col_s   = col_r;
        nxt_row_s   = row_r;
        step_col_s  = ((col_r + LANES_C) < size_r) && ((x0_r + col_r + LANES_C) < SW_C);
        if (load) begin
            base_x0_s   = {1'b0, tile_x};
            base_y0_s   = {1'b0, tile_y};
            base_size_s = CW1'(tile_size);
            nxt_col_s   = '0;
            nxt_row_s   = '0;
        end else if (advance) begin
            if (step_col_s) begin
                nxt_col_s = col_r + LANES_C;
                nxt_row_s = row_r;
            end else begin
                nxt_col_s = '0;
                nxt_row_s = row_r + ONE_C;
            end
        end else begin
            nxt_col_s = col_r;
            nxt_row_s = row_r;
        end
    end

    // Lane mask and last-span flag for the selected position.
    always_comb begin
        nxt_x_s    = base_x0_s + nxt_col_s;
        nxt_y_s    = base_y0_s + nxt_row_s;
        nxt_mask_s = '0;
        for (int k = 0; k < LANES; k++) begin
            nxt_mask_s[k] = ((nxt_col_s + CW1'(k)) < base_size_s) && ((nxt_x_s + CW1'(k)) < SW_C);
        end
        more_cols_s = ((nxt_col_s + LANES_C) < base_size_s) && ((nxt_x_s + LANES_C) < SW_C);
        more_rows_s = ((nxt_row_s + ONE_C) < base_size_s) && ((nxt_y_s + ONE_C) < SH_C);
        nxt_last_s  = !more_cols_s && !more_rows_s;
    end

    // Span and walk-position registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            x0_r     <= '0;
            y0_r     <= '0;
            size_r   <= '0;
            col_r    <= '0;
            row_r    <= '0;
            span_x_r <= '0;
            span_y_r <= '0;
            mask_r   <= '0;
            last_r   <= 1'b0;
        end else if (load || advance) begin
            x0_r     <= base_x0_s;
            y0_r     <= base_y0_s;
            size_r   <= base_size_s;
            col_r    <= nxt_col_s;
            row_r    <= nxt_row_s;
            span_x_r <= nxt_x_s[COORD_W-1:0];
            span_y_r <= nxt_y_s[COORD_W-1:0];
            mask_r   <= nxt_mask_s;
            last_r   <= nxt_last_s;
        end
    end

    assign span_x    = span_x_r;
    assign span_y    = span_y_r;
    assign span_mask = mask_r;
    assign span_last = last_r;

endmodule

// File: rtl/ren_tile_dispatch.sv
// Tile dispatcher: pops tile descriptors from a FWFT shader queue, drops invalid or
// off-screen tiles and streams lane spans to the shader array with valid/ready.
module ren_tile_dispatch
    import ren_tile_dispatch_pkg::*;
#(
    parameter int COORD_W  = 11,
    parameter int SCREEN_W = 1280,
    parameter int SCREEN_H = 720,
    parameter int LANES    = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_empty,
    input  logic [COORD_W-1:0] i_tile_x,
    input  logic [COORD_W-1:0] i_tile_y,
    input  logic [4:0]         i_tile_size,
    output logic               o_pop,
    output logic               o_valid,
    input  logic               i_ready,
    output logic [COORD_W-1:0] o_x,
    output logic [COORD_W-1:0] o_y,
    output logic [LANES-1:0]   o_mask,
    output logic               o_last,
    output logic               o_busy,
    output logic [15:0]        o_tile_cnt,
    output logic [15:0]        o_drop_cnt
);

    localparam int CW1 = COORD_W + 1;
    localparam logic [CW1-1:0] SW_C  = CW1'(SCREEN_W);
    localparam logic [CW1-1:0] SH_C  = CW1'(SCREEN_H);
    localparam logic [4:0]     MAX_C = 5'(MAX_TILE);

    disp_state_t        state_r, state_nxt_s;
    logic               pop_s, load_s, advance_s, drop_s, done_s;
    logic               tile_ok_s, accept_s;
    logic [15:0]        tile_cnt_r, drop_cnt_r;
    logic [COORD_W-1:0] span_x_s, span_y_s;
    logic [LANES-1:0]   span_mask_s;
    logic               span_last_s;

    // Validity of the descriptor currently at the queue head.
    always_comb begin
        tile_ok_s = (i_tile_size != 5'd0) && (i_tile_size <= MAX_C) &&
                    ({1'b0, i_tile_x} < SW_C) && ({1'b0, i_tile_y} < SH_C);
    end

    assign accept_s = (state_r == ST_EMIT) && i_ready;

    // Next state, pop and walker control; a pop is suppressed while reset is held.
    always_comb begin
        state_nxt_s = state_r;
        pop_s       = 1'b0;
        load_s      = 1'b0;
        advance_s   = 1'b0;
        drop_s      = 1'b0;
        done_s      = 1'b0;
        if (rst) begin
            state_nxt_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    state_nxt_s = ST_IDLE;
                end
                ST_EMIT: begin
                    if (accept_s && span_last_s) begin
                        done_s      = 1'b1;
                        state_nxt_s = ST_IDLE;
                    end else if (accept_s) begin
                        advance_s   = 1'b1;
                        state_nxt_s = ST_EMIT;
                    end else begin
                        state_nxt_s = ST_EMIT;
                    end
                end
                default: begin
                    state_nxt_s = ST_IDLE;
                end
            endcase
            // Head fetch happens from IDLE or back-to-back as the last span is taken.
            if (!i_empty && ((state_r == ST_IDLE) || done_s)) begin
                pop_s = 1'b1;
                if (tile_ok_s) begin
                    load_s      = 1'b1;
                    state_nxt_s = ST_EMIT;
                end else begin
                    drop_s      = 1'b1;
                    state_nxt_s = ST_IDLE;
                end
            end else begin
                pop_s = 1'b0;
            end
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Saturating completed/dropped tile counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            tile_cnt_r <= 16'd0;
            drop_cnt_r <= 16'd0;
        end else begin
            if (done_s) begin
                tile_cnt_r <= sat_inc16(tile_cnt_r);
            end
            if (drop_s) begin
                drop_cnt_r <= sat_inc16(drop_cnt_r);
            end
        end
    end

    ren_span_walker #(
        .COORD_W  (COORD_W),
        .SCREEN_W (SCREEN_W),
        .SCREEN_H (SCREEN_H),
        .LANES    (LANES)
    ) u_walker (
        .clk       (clk),
        .rst       (rst),
        .load      (load_s),
        .advance   (advance_s),
        .tile_x    (i_tile_x),
        .tile_y    (i_tile_y),
        .tile_size (i_tile_size),
        .span_x    (span_x_s),
        .span_y    (span_y_s),
        .span_mask (span_mask_s),
        .span_last (span_last_s)
    );

    assign o_pop      = pop_s;
    assign o_valid    = (state_r == ST_EMIT);
    assign o_busy     = (state_r == ST_EMIT);
    assign o_x        = span_x_s;
    assign o_y        = span_y_s;
    assign o_mask     = span_mask_s;
    assign o_last     = span_last_s && (state_r == ST_EMIT);
    assign o_tile_cnt = tile_cnt_r;
    assign o_drop_cnt = drop_cnt_r;

endmodule
